dac_sample_pacer: RTL and testbench
===================================

DAC_SAMPLE_PACER -- requirements
Module: dac_sample_pacer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in samples (power of two, 4..256).
REQ-002 SHALL have parameter DIV_W, default 16, width of the rate divisor.
REQ-003 SHALL have port clk_fast  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_data  input  12  sample from the producer.
REQ-006 SHALL have port s_valid  input  1  s_data is valid.
REQ-007 SHALL have port s_ready  output  1  FIFO can accept; a push occurs when s_valid and s_ready are both high.
REQ-008 SHALL have port div  input  DIV_W  sample period minus one, in clk_fast cycles.
REQ-009 SHALL have port enable  input  1  pacing enabled.
REQ-010 SHALL have port test_en  input  1  ramp test source select (see Configuration).
REQ-011 SHALL have port clr_flags  input  1  synchronous clear of sticky flags.
REQ-012 SHALL have port sample  output  12  registered 12-bit sample to the DAC controller.
REQ-013 SHALL have port sample_stb  output  1  one-cycle pulse when sample updates.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 SHALL have port underrun  output  1  sticky flag: a tick found the FIFO empty.

Function
REQ-016 SHALL run the divider counter cnt from 0 and assert tick when enable=1 and cnt>=div; on tick, cnt returns to 0; otherwise cnt increments.
REQ-017 SHALL hold cnt at 0 with no ticks while enable=0; the FIFO keeps accepting pushes.
REQ-018 SHALL, with div=0 and enable=1, tick every cycle.
REQ-019 SHALL, when div is lowered below cnt mid-period, tick on the next cycle (the >= compare).
REQ-020 SHALL, on tick with FIFO non-empty, pop the head; sample SHALL equal the head and sample_stb SHALL be 1 in the cycle after the tick (latency 1).
REQ-021 SHALL, on tick with FIFO empty, hold sample, keep sample_stb at 0, and set underrun.
REQ-022 SHALL drive s_ready = (level < DEPTH); when full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-023 SHALL, when empty, with push and tick in the same cycle, perform no fall-through: underrun is set and the pushed word is stored (level becomes 1).
REQ-024 SHALL update level by +1 on a push, -1 on a pop, and leave it unchanged on a simultaneous push and pop.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH.
REQ-026 SHALL clear underrun on clr_flags; a set and a clear in the same cycle SHALL leave underrun at 1.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force sample=12'h800 (midscale), sample_stb=0, level=0, underrun=0, cnt=0, and pointers=0; s_ready SHALL then be 1.
REQ-028 SHALL discard FIFO contents on a reset asserted mid-operation; the first tick after release with no pushes SHALL set underrun.

Configuration
REQ-029 SHALL compile the ramp test source only when DAC_PACER_RAMP_EN is defined.
REQ-030 SHALL, with DAC_PACER_RAMP_EN and test_en=1, on each tick set sample to sample+1 modulo 4096 and pulse sample_stb; the FIFO is not popped and underrun is not set.
REQ-031 SHALL, without DAC_PACER_RAMP_EN, ignore test_en completely.

Structure
REQ-032 SHALL take SAMPLE_W=12 and DAC_MIDSCALE=12'h800 from shared package dac_pkg, which the DAC controller also uses.
REQ-033 SHALL implement storage in sub-module dac_sync_fifo (push/pop/level/full/empty). The divider, sample register and flags SHALL stay in dac_sample_pacer.

Verification
REQ-034 Reset, no stimulus -> sample=0x800, sample_stb=0, s_ready=1, level=0, underrun=0.
REQ-035 div=3, enable=1, push 0x001,0x002,0x003 -> sample_stb every 4th cycle, samples 0x001,0x002,0x003 in order, then underrun=1 with sample held at 0x003.
REQ-036 DEPTH=16, enable=0, push 17 words -> s_ready=0 after the 16th push, level=16, 17th word not accepted.
REQ-037 Full FIFO, enable=1, div=0, s_valid held high -> level stays at 16 or 15, no word lost or duplicated (scoreboard).
REQ-038 Empty FIFO, push and tick in the same cycle -> underrun=1, level=1, no sample_stb; clr_flags then clears underrun.
REQ-039 DAC_PACER_RAMP_EN, test_en=1, div=0, from sample=0xFFE -> 0xFFF, 0x000, 0x001 on consecutive cycles; level unchanged.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared DAC definitions: sample width, midscale code and the sample-source
// selector used by the pacer. The DAC controller imports the same package.
package dac_pkg;

    localparam int SAMPLE_W = 12;
    localparam logic [SAMPLE_W-1:0] DAC_MIDSCALE = 12'h800;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_FIFO = 2'd1,
        SRC_RAMP = 2'd2
    } sample_src_e;

endpackage

// File: rtl/dac_sync_fifo.sv
// Single-clock sample FIFO with occupancy count. A push is refused whenever the
// FIFO is full, and a pop on an empty FIFO is ignored, so there is no fall-through.
module dac_sync_fifo
    import dac_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  sample_t                  data_i,
    input  logic                     pop_i,
    output sample_t                  data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;
    sample_t       mem_q [DEPTH];

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_ok) begin
            wr_ptr_d = AW'(wr_ptr_q + 1'b1);
        end
        if (pop_ok) begin
            rd_ptr_d = AW'(rd_ptr_q + 1'b1);
        end
        if (push_ok && !pop_ok) begin
            level_d = (AW+1)'(level_q + 1'b1);
        end else if (pop_ok && !push_ok) begin
            level_d = (AW+1)'(level_q - 1'b1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces buffered samples out to the DAC at clk_fast/(div+1). Defining
// DAC_PACER_RAMP_EN builds a ramp test source selected by test_en.
module dac_sample_pacer
    import dac_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                     clk_fast,
    input  logic                     rst_n,
    input  logic [SAMPLE_W-1:0]      s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DIV_W-1:0]         div,
    input  logic                     enable,
    input  logic                     test_en,
    input  logic                     clr_flags,
    output logic [SAMPLE_W-1:0]      sample,
    output logic                     sample_stb,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    sample_t          sample_q, sample_d;
    logic             stb_q, stb_d;
    logic             underrun_q, underrun_d;
    logic             tick, pop, push, ramp_sel;
    logic             fifo_full, fifo_empty;
    sample_t          fifo_data;
    sample_src_e      src;

`ifdef DAC_PACER_RAMP_EN
    assign ramp_sel = test_en;
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
    assign ramp_sel       = 1'b0;
`endif

    assign s_ready = !fifo_full;
    assign push    = s_valid && s_ready;

    dac_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_fast),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (s_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The >= compare makes a lowered div take effect on the very next cycle.
    always_comb begin
        tick       = enable && (cnt_q >= div);
        src        = SRC_NONE;
        pop        = 1'b0;
        underrun_d = underrun_q && !clr_flags;
        cnt_d      = '0;
        if (enable && !tick) begin
            cnt_d = DIV_W'(cnt_q + 1'b1);
        end
        if (tick) begin
            if (ramp_sel) begin
                src = SRC_RAMP;
            end else if (!fifo_empty) begin
                src = SRC_FIFO;
                pop = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end
        case (src)
            SRC_FIFO: sample_d = fifo_data;
            SRC_RAMP: sample_d = sample_t'(sample_q + 1'b1);
            default:  sample_d = sample_q;
        endcase
        stb_d = (src != SRC_NONE);
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sample_q   <= DAC_MIDSCALE;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            stb_q      <= stb_d;
            underrun_q <= underrun_d;
        end
    end

    assign sample     = sample_q;
    assign sample_stb = stb_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed self-checking bench for dac_sample_pacer (DEPTH=16, DIV_W=16).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_dac_sample_pacer;

    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] div;
    logic        enable;
    logic        test_en;
    logic        clr_flags;
    logic [11:0] sample;
    logic        sample_stb;
    logic [4:0]  level;
    logic        underrun;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [11:0] scoreQ [$];
    logic [11:0] expSample;
    logic [11:0] nextData;
    int          modelLevel;
    logic        pushOk;
    logic        popped;

    dac_sample_pacer #(
        .DEPTH (16),
        .DIV_W (16)
    ) dut (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .div        (div),
        .enable     (enable),
        .test_en    (test_en),
        .clr_flags  (clr_flags),
        .sample     (sample),
        .sample_stb (sample_stb),
        .level      (level),
        .underrun   (underrun)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic stepClock();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushWord(input logic [11:0] value);
        s_valid = 1'b1;
        s_data  = value;
        stepClock();
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; div = 16'd3;
        enable = 1'b0; test_en = 1'b0; clr_flags = 1'b0;
        repeat (3) stepClock();
        checkOutput("rst_sample", sample, 12'h800);
        checkOutput("rst_stb", sample_stb, 1'b0);
        checkOutput("rst_sready", s_ready, 1'b1);
        checkOutput("rst_level", level, 5'd0);
        checkOutput("rst_underrun", underrun, 1'b0);
        rst_n = 1'b1;
        stepClock();

        // Paced playback of three words at div=3, then an underrun.
        pushWord(12'h001);
        pushWord(12'h002);
        pushWord(12'h003);
        checkOutput("pace_level", level, 5'd3);
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            stepClock();
            checkOutput($sformatf("pace_stb_%0d", k), sample_stb, (k % 4 == 0) && (k <= 12));
            if ((k % 4 == 0) && (k <= 12))
                checkOutput($sformatf("pace_sample_%0d", k), sample, k / 4);
            if (k == 12)
                checkOutput("pace_no_underrun", underrun, 1'b0);
        end
        checkOutput("pace_underrun", underrun, 1'b1);
        checkOutput("pace_hold", sample, 12'h003);
        enable = 1'b0;
        clr_flags = 1'b1;
        stepClock();
        clr_flags = 1'b0;
        checkOutput("pace_clr", underrun, 1'b0);

        // Lowering div below the running count ticks on the next cycle.
        div = 16'd10;
        pushWord(12'h0AB);
        enable = 1'b1;
        repeat (5) stepClock();
        checkOutput("lowdiv_wait", sample_stb, 1'b0);
        div = 16'd2;
        stepClock();
        checkOutput("lowdiv_stb", sample_stb, 1'b1);
        checkOutput("lowdiv_sample", sample, 12'h0AB);
        enable = 1'b0;

        // Fill to 16 with enable low; the 17th word is refused.
        for (int i = 0; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 12'h100 + 12'(i);
            checkOutput($sformatf("fill_sready_%0d", i), s_ready, i < 16);
            if (i < 16) scoreQ.push_back(12'h100 + 12'(i));
            stepClock();
        end
        s_valid = 1'b0;
        checkOutput("fill_level", level, 5'd16);
        checkOutput("fill_sready", s_ready, 1'b0);

        // Full FIFO drained at div=0 while the producer streams.
        div = 16'd0;
        enable = 1'b1;
        modelLevel = 16;
        nextData = 12'h200;
        expSample = 12'h0AB;
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1;
            s_data  = nextData;
            pushOk  = (modelLevel < 16);
            checkOutput($sformatf("stream_sready_%0d", c), s_ready, pushOk);
            stepClock();
            popped = (modelLevel > 0);
            if (popped) expSample = scoreQ.pop_front();
            if (pushOk) begin
                scoreQ.push_back(nextData);
                nextData = nextData + 12'd1;
            end
            modelLevel = modelLevel + int'(pushOk) - int'(popped);
            checkOutput($sformatf("stream_stb_%0d", c), sample_stb, popped);
            checkOutput($sformatf("stream_sample_%0d", c), sample, expSample);
            checkOutput($sformatf("stream_level_%0d", c), level, modelLevel);
        end
        s_valid = 1'b0;
        enable = 1'b0;

        // Reset mid-operation discards the FIFO.
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_level", level, 5'd0);
        checkOutput("midrst_sample", sample, 12'h800);
        checkOutput("midrst_sready", s_ready, 1'b1);
        stepClock();
        rst_n = 1'b1;
        enable = 1'b1;
        stepClock();
        checkOutput("midrst_underrun", underrun, 1'b1);
        checkOutput("midrst_stb", sample_stb, 1'b0);
        enable = 1'b0;
        clr_flags = 1'b1;
        stepClock();
        clr_flags = 1'b0;
        checkOutput("midrst_clr", underrun, 1'b0);

        // Push and tick together on an empty FIFO: no fall-through.
        enable = 1'b1;
        s_valid = 1'b1;
        s_data = 12'h3C3;
        stepClock();
        s_valid = 1'b0;
        enable = 1'b0;
        checkOutput("pt_underrun", underrun, 1'b1);
        checkOutput("pt_level", level, 5'd1);
        checkOutput("pt_stb", sample_stb, 1'b0);
        clr_flags = 1'b1;
        stepClock();
        clr_flags = 1'b0;
        checkOutput("pt_clr", underrun, 1'b0);
        enable = 1'b1;
        stepClock();
        checkOutput("pt_pop_stb", sample_stb, 1'b1);
        checkOutput("pt_pop_sample", sample, 12'h3C3);
        checkOutput("pt_pop_level", level, 5'd0);
        clr_flags = 1'b1;
        stepClock();
        clr_flags = 1'b0;
        enable = 1'b0;
        checkOutput("setclr_underrun", underrun, 1'b1);
        checkOutput("setclr_stb", sample_stb, 1'b0);
        clr_flags = 1'b1;
        stepClock();
        clr_flags = 1'b0;
        checkOutput("setclr_clr", underrun, 1'b0);

        // Ramp source from 0xFFE (or test_en ignored in the default build).
        pushWord(12'hFFE);
        pushWord(12'h555);
        enable = 1'b1;
        stepClock();
        checkOutput("ramp_start", sample, 12'hFFE);
        checkOutput("ramp_start_level", level, 5'd1);
        test_en = 1'b1;
`ifdef DAC_PACER_RAMP_EN
        for (int r = 0; r < 3; r++) begin
            stepClock();
            checkOutput($sformatf("ramp_sample_%0d", r), sample, 12'hFFF + 12'(r + 1) - 12'd1 + 12'd0);
            checkOutput($sformatf("ramp_stb_%0d", r), sample_stb, 1'b1);
            checkOutput($sformatf("ramp_level_%0d", r), level, 5'd1);
        end
        checkOutput("ramp_underrun", underrun, 1'b0);
`else
        stepClock();
        checkOutput("noramp_sample", sample, 12'h555);
        checkOutput("noramp_stb", sample_stb, 1'b1);
        checkOutput("noramp_level", level, 5'd0);
        stepClock();
        checkOutput("noramp_underrun", underrun, 1'b1);
`endif
        enable = 1'b0;
        test_en = 1'b0;
        stepClock();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
